alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  block can accept an instruction.
REQ-006 instr_mode  in  4  ALU operation code (0000..1111).
REQ-007 instr_opb  in  8  memory/immediate operand.
REQ-008 alu_en  out  1  ALU enable, high only in EXEC.
REQ-009 alu_mode  out  4  latched opcode to ALU.
REQ-010 alu_op1  out  8  accumulator value to ALU.
REQ-011 alu_op2  out  8  latched operand to ALU.
REQ-012 alu_result  in  8  ALU combinational result.
REQ-013 alu_flags  in  4  ALU flags {Z,C,S,O}.
REQ-014 acc  out  8  accumulator register.
REQ-015 sr  out  4  status register {Z,C,S,O}.
REQ-016 wb_valid  out  1  memory write-back offered.
REQ-017 wb_data  out  8  memory write-back data.
REQ-018 wb_ready  in  1  memory sink accepts write-back.
REQ-019 retire_cnt  out  CNT_W  completed-instruction count.

Function
REQ-020 FSM states IDLE, EXEC, WB_MEM; instr_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on instr_valid && instr_ready, latch instr_mode/instr_opb and go to EXEC next cycle; otherwise stay.
REQ-022 EXEC lasts exactly one cycle: alu_en=1, alu_mode/alu_op2 = latched values, alu_op1 = acc; alu_result/alu_flags sampled at end of this cycle.
REQ-023 Destination SHALL be MEM for modes 0010, 0111, 1000, 1001; ACC for all other modes.
REQ-024 ACC destination: acc <= alu_result at end of EXEC; next state IDLE (accept-to-accept spacing 2 cycles).
REQ-025 MEM destination: acc unchanged; wb_data <= alu_result at end of EXEC; next state WB_MEM.
REQ-026 WB_MEM: wb_valid=1, wb_data stable until wb_valid && wb_ready; on that handshake return to IDLE next cycle; no timeout.
REQ-027 sr <= alu_flags at end of EXEC for every mode except 0010 (store), which leaves sr unchanged.
REQ-028 Outside EXEC, alu_en=0; alu_mode/alu_op2 hold last latched values.
REQ-029 retire_cnt increments by 1 at end of EXEC for ACC destination, and on the wb handshake cycle for MEM destination; wraps modulo 2^CNT_W.
REQ-030 instr_valid while not in IDLE SHALL be ignored (no latch, no drop counting).
REQ-031 Operand width 8 bits throughout; no internal arithmetic besides the counter.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE, acc=0, sr=0, wb_data=0, retire_cnt=0, latched mode/operand=0, regardless of state (including mid-EXEC or WB_MEM).
REQ-033 While rst is high: instr_ready=0, alu_en=0, wb_valid=0; instr_ready=1 on the first cycle after rst deasserts.

Structure
REQ-034 Shared package SHALL hold the 4-bit opcode constants, the FSM state enum, and the ACC/MEM destination-decode function.
REQ-035 No sub-module inside; the ALU is connected beside this block at the next level. The counter MAY be a separate sub-module named retire_counter.

Verification (bench connects the team's ALU to alu_* ports)
REQ-036 After reset, mode 0011 opb 0x7F then mode 0000 opb 0x01 -> acc=0x80, sr=4'b0011, retire_cnt=2.
REQ-037 acc=0x80, mode 0010, wb_ready low 3 cycles -> wb_valid=1, wb_data=0x80 stable, instr_ready=0, sr unchanged; retire_cnt increments on handshake only.
REQ-038 Mode 1000 opb 0xFF -> wb_data=0x00, sr=4'b1100, acc unchanged.
REQ-039 instr_valid held high with three ACC-dest instructions -> accepts at cycles N, N+2, N+4; retire_cnt=3.
REQ-040 rst asserted during WB_MEM -> next cycle wb_valid=0, acc=0, sr=0, retire_cnt=0, IDLE after release.
REQ-041 CNT_W=4, 16 ACC-dest instructions -> retire_cnt wraps 15 -> 0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg -- opcode constants, FSM states and destination decode for the ALU issue controller.
// Rev 1.0
`default_nettype none

package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_STORE     = 4'b0010;
  localparam logic [3:0] OP_STORE_NOT = 4'b0111;
  localparam logic [3:0] OP_INC_MEM   = 4'b1000;
  localparam logic [3:0] OP_DEC_MEM   = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_WB_MEM = 2'd2
  } state_t;

  function automatic logic is_mem_dest(input logic [3:0] mode);
    return (mode == OP_STORE) || (mode == OP_STORE_NOT) ||
           (mode == OP_INC_MEM) || (mode == OP_DEC_MEM);
  endfunction

  // A plain store must not disturb the flags left by the previous operation.
  function automatic logic updates_sr(input logic [3:0] mode);
    return mode != OP_STORE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_retire_counter.sv
// retire_counter -- free-running wrap-around count of completed instructions.
// Rev 1.0
`default_nettype none

module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- issues one instruction at a time to an external ALU and retires to ACC or memory.
// Rev 1.0
`default_nettype none

module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_mode,
  input  logic [7:0]       instr_opb,
  output logic             alu_en,
  output logic [3:0]       alu_mode,
  output logic [7:0]       alu_op1,
  output logic [7:0]       alu_op2,
  input  logic [7:0]       alu_result,
  input  logic [3:0]       alu_flags,
  output logic [7:0]       acc,
  output logic [3:0]       sr,
  output logic             wb_valid,
  output logic [7:0]       wb_data,
  input  logic             wb_ready,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] mode_q;
  logic [7:0] opb_q;
  logic       accept;
  logic       retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are gated by rst so nothing is offered while reset is held.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    wb_valid    = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = !rst;
        accept      = instr_valid && !rst;
        if (accept) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = !rst;
        if (is_mem_dest(mode_q)) begin
          state_nxt = S_WB_MEM;
        end else begin
          state_nxt = S_IDLE;
          retire    = 1'b1;
        end
      end
      S_WB_MEM: begin
        wb_valid = !rst;
        if (wb_ready) begin
          state_nxt = S_IDLE;
          retire    = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      opb_q   <= '0;
      acc     <= '0;
      sr      <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        mode_q <= instr_mode;
        opb_q  <= instr_opb;
      end
      if (state == S_EXEC) begin
        if (is_mem_dest(mode_q)) begin
          wb_data <= alu_result;
        end else begin
          acc <= alu_result;
        end
        if (updates_sr(mode_q)) begin
          sr <= alu_flags;
        end
      end
    end
  end

  assign alu_mode = mode_q;
  assign alu_op1  = acc;
  assign alu_op2  = opb_q;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (retire_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl -- directed vectors plus hand sequences; a small behavioural ALU sits beside each DUT.
// Rev 1.0
`default_nettype none

module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] instr_mode;
  logic [7:0] instr_opb;
  logic       wb_ready;

  logic        instr_ready, alu_en, wb_valid;
  logic [3:0]  alu_mode, alu_flags, sr;
  logic [7:0]  alu_op1, alu_op2, alu_result, acc, wb_data;
  logic [15:0] retire_cnt;

  logic       instr_ready2, alu_en2, wb_valid2;
  logic [3:0] alu_mode2, alu_flags2, sr2;
  logic [7:0] alu_op1_2, alu_op2_2, alu_result2, acc2, wb_data2;
  logic [3:0] retire_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_mode(instr_mode), .instr_opb(instr_opb), .alu_en(alu_en), .alu_mode(alu_mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result), .alu_flags(alu_flags),
    .acc(acc), .sr(sr), .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
    .retire_cnt(retire_cnt)
  );

  alu_issue_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready2),
    .instr_mode(instr_mode), .instr_opb(instr_opb), .alu_en(alu_en2), .alu_mode(alu_mode2),
    .alu_op1(alu_op1_2), .alu_op2(alu_op2_2), .alu_result(alu_result2), .alu_flags(alu_flags2),
    .acc(acc2), .sr(sr2), .wb_valid(wb_valid2), .wb_data(wb_data2), .wb_ready(wb_ready),
    .retire_cnt(retire_cnt2)
  );

  // Team ALU stand-in: returns {Z,C,S,O,result}.
  function automatic logic [11:0] alu_f(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, o;
    t = '0; c = 1'b0; o = 1'b0;
    case (m)
      4'b0000: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b0001: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b0010: r = a;
      4'b0011: r = b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~a;
      4'b1000: begin t = {1'b0, b} + 9'd1; r = t[7:0]; c = t[8]; o = (b == 8'h7F); end
      4'b1001: begin t = {1'b0, b} - 9'd1; r = t[7:0]; c = t[8]; o = (b == 8'h80); end
      default: r = b;
    endcase
    if (m == 4'b0010) return {4'b0000, r};
    return {(r == 8'h00), c, r[7], o, r};
  endfunction

  always_comb {alu_flags, alu_result}   = alu_f(alu_mode, alu_op1, alu_op2);
  always_comb {alu_flags2, alu_result2} = alu_f(alu_mode2, alu_op1_2, alu_op2_2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one instruction from an IDLE negedge; returns at the next IDLE negedge.
  task automatic run_instr(input logic [3:0] m, input logic [7:0] b, input bit mem, output logic [7:0] wbd);
    wbd = 8'h00;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr_mode = m; instr_opb = b;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("alu_en_exec", 32'(alu_en), 32'd1);
    chk("alu_mode_exec", 32'(alu_mode), 32'(m));
    @(negedge clk);
    if (mem) begin
      chk("wb_valid", 32'(wb_valid), 32'd1);
      wbd = wb_data;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] mode;
    logic [7:0] opb;
    bit         mem;
    logic [7:0] acc;
    logic [3:0] sr;
    logic [7:0] wb;
    int         cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0] wbd;
    vecs[0]  = '{4'b0011, 8'h7F, 1'b0, 8'h7F, 4'b0000, 8'h00, 1};
    vecs[1]  = '{4'b0000, 8'h01, 1'b0, 8'h80, 4'b0011, 8'h00, 2};
    vecs[2]  = '{4'b0010, 8'h00, 1'b1, 8'h80, 4'b0011, 8'h80, 3};
    vecs[3]  = '{4'b1000, 8'hFF, 1'b1, 8'h80, 4'b1100, 8'h00, 4};
    vecs[4]  = '{4'b0001, 8'h80, 1'b0, 8'h00, 4'b1000, 8'h00, 5};
    vecs[5]  = '{4'b0011, 8'hA5, 1'b0, 8'hA5, 4'b0010, 8'h00, 6};
    vecs[6]  = '{4'b0100, 8'h0F, 1'b0, 8'h05, 4'b0000, 8'h00, 7};
    vecs[7]  = '{4'b0101, 8'hF0, 1'b0, 8'hF5, 4'b0010, 8'h00, 8};
    vecs[8]  = '{4'b0110, 8'hF5, 1'b0, 8'h00, 4'b1000, 8'h00, 9};
    vecs[9]  = '{4'b1001, 8'h00, 1'b1, 8'h00, 4'b0110, 8'hFF, 10};
    vecs[10] = '{4'b0111, 8'h00, 1'b1, 8'h00, 4'b0010, 8'hFF, 11};
    vecs[11] = '{4'b0000, 8'hFF, 1'b0, 8'hFF, 4'b0010, 8'h00, 12};
    vecs[12] = '{4'b0000, 8'h01, 1'b0, 8'h00, 4'b1100, 8'h00, 13};
    vecs[13] = '{4'b1111, 8'h3C, 1'b0, 8'h3C, 4'b0000, 8'h00, 14};

    rst = 1'b1; instr_valid = 1'b0; instr_mode = 4'h0; instr_opb = 8'h00; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_acc", 32'(acc), 32'd0);
    chk("reset_sr", 32'(sr), 32'd0);
    chk("reset_cnt", 32'(retire_cnt), 32'd0);
    chk("reset_wb_data", 32'(wb_data), 32'd0);
    chk("reset_alu_op2", 32'(alu_op2), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].mode, vecs[i].opb, vecs[i].mem, wbd);
      chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].acc));
      chk($sformatf("vec%0d_sr", i), 32'(sr), 32'(vecs[i].sr));
      chk($sformatf("vec%0d_cnt", i), 32'(retire_cnt), 32'(vecs[i].cnt));
      if (vecs[i].mem) chk($sformatf("vec%0d_wb", i), 32'(wbd), 32'(vecs[i].wb));
    end

    // Back-to-back ACC instructions with valid held high: accepts every other cycle.
    instr_valid = 1'b1; instr_mode = 4'b0000; instr_opb = 8'h01;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b2b_ready%0d", k), 32'(instr_ready), 32'((k % 2) == 0));
      chk($sformatf("b2b_alu_en%0d", k), 32'(alu_en), 32'((k % 2) == 1));
      if (k == 5) instr_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_acc", 32'(acc), 32'h3F);
    chk("b2b_cnt", 32'(retire_cnt), 32'd17);

    run_instr(4'b0011, 8'h80, 1'b0, wbd);
    chk("load80_sr", 32'(sr), 32'b0010);

    // Store under back-pressure, with ignored valid offered throughout.
    instr_valid = 1'b1; instr_mode = 4'b0010; instr_opb = 8'h11;
    @(negedge clk);
    instr_mode = 4'b0000; instr_opb = 8'h55;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("bp_wb_valid", 32'(wb_valid), 32'd1);
      chk("bp_wb_data", 32'(wb_data), 32'h80);
      chk("bp_instr_ready", 32'(instr_ready), 32'd0);
      chk("bp_sr", 32'(sr), 32'b0010);
      chk("bp_cnt", 32'(retire_cnt), 32'd18);
      chk("bp_alu_mode", 32'(alu_mode), 32'b0010);
      chk("bp_alu_op2", 32'(alu_op2), 32'h11);
      if (k == 2) begin
        wb_ready = 1'b1; instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    wb_ready = 1'b0;
    chk("bp_cnt_after", 32'(retire_cnt), 32'd19);
    chk("bp_wb_valid_after", 32'(wb_valid), 32'd0);
    chk("bp_ready_after", 32'(instr_ready), 32'd1);
    chk("bp_acc_after", 32'(acc), 32'h80);

    // Reset while waiting in WB_MEM.
    instr_valid = 1'b1; instr_mode = 4'b0010; instr_opb = 8'h22;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rwb_wb_valid_pre", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rwb_wb_valid", 32'(wb_valid), 32'd0);
    chk("rwb_acc", 32'(acc), 32'd0);
    chk("rwb_sr", 32'(sr), 32'd0);
    chk("rwb_cnt", 32'(retire_cnt), 32'd0);
    chk("rwb_wb_data", 32'(wb_data), 32'd0);
    chk("rwb_ready_in_rst", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rwb_ready_after", 32'(instr_ready), 32'd1);
    chk("rwb_cnt4", 32'(retire_cnt2), 32'd0);

    // 4-bit counter wraps 15 -> 0 on the sixteenth retirement.
    for (int i = 0; i < 16; i++) begin
      run_instr(4'b0011, 8'(i), 1'b0, wbd);
      chk($sformatf("wrap_cnt4_%0d", i), 32'(retire_cnt2), 32'((i + 1) % 16));
    end
    chk("wrap_cnt16", 32'(retire_cnt), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
